// File: rtl/reg_alu_ctrl_pkg.sv
// reg_alu_ctrl shared definitions: instruction classes,
// field positions, FSM states and the decode helper.
package reg_alu_ctrl_pkg;

    localparam logic [1:0] CLS_ALU   = 2'b00;
    localparam logic [1:0] CLS_LOADI = 2'b01;
    localparam logic [1:0] CLS_NOP   = 2'b10;
    localparam logic [1:0] CLS_RSVD  = 2'b11;

    localparam int CLS_HI    = 15;
    localparam int CLS_LO    = 14;
    localparam int OP_HI     = 13;
    localparam int OP_LO     = 12;
    localparam int ALU_WA_HI = 11;
    localparam int ALU_WA_LO = 9;
    localparam int RA_HI     = 8;
    localparam int RA_LO     = 6;
    localparam int RB_HI     = 5;
    localparam int RB_LO     = 3;
    localparam int LDI_WA_HI = 13;
    localparam int LDI_WA_LO = 11;
    localparam int IMM_HI    = 10;
    localparam int IMM_LO    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FLAG = 2'd2
    } state_e;

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [1:0]  op;
        logic [2:0]  rd_a;
        logic [2:0]  rd_b;
        logic [2:0]  wa;
        logic [15:0] d_in;
    } ctrl_t;

    // Static field decode; wr/sel are gated by the FSM in the top.
    function automatic ctrl_t decode(input logic [15:0] ir);
        ctrl_t c;
        logic [1:0] cls;
        cls    = ir[CLS_HI:CLS_LO];
        c.sel  = (cls == CLS_ALU);
        c.wr   = (cls == CLS_ALU) || (cls == CLS_LOADI);
        c.op   = ir[OP_HI:OP_LO];
        c.rd_a = ir[RA_HI:RA_LO];
        c.rd_b = ir[RB_HI:RB_LO];
        c.wa   = (cls == CLS_LOADI) ? ir[LDI_WA_HI:LDI_WA_LO]
                                    : ir[ALU_WA_HI:ALU_WA_LO];
        c.d_in = {8'h00, ir[IMM_HI:IMM_LO]};
        return c;
    endfunction

endpackage

// File: rtl/reg_alu_ctrl_if.sv
// reg_alu_ctrl bus: instruction handshake plus the
// register-file/ALU control bundle and returned carry.
interface reg_alu_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        cout;
    logic        sel;
    logic        wr;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;

    modport master (
        output in_valid, in_instr, cout,
        input  in_ready, sel, wr, op,
        input  rd_addr_a, rd_addr_b, wr_addr, d_in
    );

    modport slave (
        input  in_valid, in_instr, cout,
        output in_ready, sel, wr, op,
        output rd_addr_a, rd_addr_b, wr_addr, d_in
    );

endinterface

// File: rtl/reg_alu_ctrl_instr_fifo.sv
// First-word-fall-through instruction buffer with a
// registered occupancy count; pointers wrap modulo DEPTH.
module instr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign dout    = mem[rp];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/reg_alu_ctrl.sv
// reg_alu_ctrl: buffers instructions, sequences them through
// IDLE/EXEC/FLAG and drives the reg_alu control bundle.
module reg_alu_ctrl
    import reg_alu_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    reg_alu_ctrl_if.slave  bus,
    output logic           carry,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_e      state;
    state_e      state_nxt;
    logic [15:0] ir;
    logic [15:0] head;
    logic        rdy_q;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        exec;
    logic [1:0]  cls;
    ctrl_t       dec;

    assign push         = bus.in_valid & bus.in_ready;
    assign bus.in_ready = rdy_q & ~full;
    assign pop          = ~empty &
                          ((state == ST_IDLE) || (state == ST_FLAG));

    instr_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.in_instr),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Next-state: EXEC always lasts one cycle, FLAG chains
    // straight into the next EXEC when work is waiting.
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state == ST_IDLE: state_nxt = empty ? ST_IDLE : ST_EXEC;
            state == ST_EXEC: state_nxt = ST_FLAG;
            state == ST_FLAG: state_nxt = empty ? ST_IDLE : ST_EXEC;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // State, instruction register and ready-after-reset flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            ir    <= '0;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;
            if (pop) ir <= head;
        end
    end

    // Sticky carry: only ALU-class instructions sample cout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry <= 1'b0;
        end else if (state == ST_FLAG && cls == CLS_ALU) begin
            carry <= bus.cout;
        end
    end

    assign cls  = ir[CLS_HI:CLS_LO];
    assign dec  = decode(ir);
    assign exec = (state == ST_EXEC);

    assign bus.wr        = exec & dec.wr;
    assign bus.sel       = exec & dec.sel;
    assign bus.op        = dec.op;
    assign bus.rd_addr_a = dec.rd_a;
    assign bus.rd_addr_b = dec.rd_b;
    assign bus.wr_addr   = dec.wa;
    assign bus.d_in      = dec.d_in;

    assign done = (state == ST_FLAG);
    assign err  = done & (cls == CLS_RSVD);
    assign busy = (state != ST_IDLE) | ~empty;

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Scoreboard bench for reg_alu_ctrl: directed instructions
// queue their expected decode, a monitor checks at each done.
module tb_reg_alu_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic carry;
    logic busy;
    logic done;
    logic err;

    always #5 clk = ~clk;

    reg_alu_ctrl_if bus ();

    reg_alu_ctrl #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .carry (carry),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    typedef struct {
        logic [15:0] instr;
        logic        wr;
        logic        sel;
        logic [1:0]  op;
        logic [2:0]  wa;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] din;
        logic        err;
        logic        ck_rd;
        logic        ck_din;
        logic        car;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sbq[$];
    int   done_cyc[$];
    logic saw_full = 1'b0;
    logic mcarry = 1'b0;
    logic prev_wr = 1'b0;
    logic prev_sel = 1'b0;
    logic car_pend = 1'b0;
    logic car_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(
        input logic [15:0] instr, input logic wr, input logic sel,
        input logic [1:0] op, input logic [2:0] wa,
        input logic [2:0] ra, input logic [2:0] rb,
        input logic [15:0] din, input logic e,
        input logic ck_rd, input logic ck_din);
        exp_t x;
        x.instr  = instr;
        x.wr     = wr;
        x.sel    = sel;
        x.op     = op;
        x.wa     = wa;
        x.ra     = ra;
        x.rb     = rb;
        x.din    = din;
        x.err    = e;
        x.ck_rd  = ck_rd;
        x.ck_din = ck_din;
        x.car    = 1'b0;
        return x;
    endfunction

    // Monitor: EXEC always precedes FLAG, so the EXEC-cycle wr/sel
    // are remembered one cycle and checked when done appears.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            sbq.delete();
            car_pend = 1'b0;
            prev_wr  = 1'b0;
            prev_sel = 1'b0;
        end else begin
            if (car_pend) begin
                chk("carry_after_flag", carry, car_exp);
                car_pend = 1'b0;
            end
            if (done) begin
                chk("sb_has_entry", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("exec_wr", prev_wr, e.wr);
                    chk("exec_sel", prev_sel, e.sel);
                    chk("err", err, e.err);
                    if (e.wr) chk("wr_addr", bus.wr_addr, e.wa);
                    if (e.ck_rd) begin
                        chk("op", bus.op, e.op);
                        chk("rd_addr_a", bus.rd_addr_a, e.ra);
                        chk("rd_addr_b", bus.rd_addr_b, e.rb);
                    end
                    if (e.ck_din) chk("d_in", bus.d_in, e.din);
                    car_pend = 1'b1;
                    car_exp  = e.car;
                    done_cyc.push_back(cyc);
                end
            end
            prev_wr  = bus.wr;
            prev_sel = bus.sel;
        end
    end

    // Called at a negedge; returns at the negedge after transfer.
    task automatic send(input exp_t e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = e.instr;
        while (!bus.in_ready && n < 50) begin
            saw_full = 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", bus.in_ready, 1);
        if (e.instr[15:14] == 2'b00) mcarry = bus.cout;
        e.car = mcarry;
        sbq.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    exp_t burst[8];

    initial begin
        int n;
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h4FF8;
        bus.cout     = 1'b0;
        reset        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_wr", bus.wr, 0);
        chk("rst_op", bus.op, 0);
        chk("rst_rd_a", bus.rd_addr_a, 0);
        chk("rst_rd_b", bus.rd_addr_b, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_d_in", bus.d_in, 0);
        chk("rst_carry", carry, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_busy", busy, 0);

        send(mk(16'h4FF8, 1, 0, 2'b00, 3'd1, 3'd0, 3'd0,
                16'h00FF, 0, 0, 1));
        wait_idle();
        chk("carry_after_loadi", carry, 0);

        bus.cout = 1'b1;
        send(mk(16'h0650, 1, 1, 2'b00, 3'd3, 3'd1, 3'd2,
                16'h0000, 0, 1, 0));
        wait_idle();
        chk("carry_after_alu", carry, 1);
        bus.cout = 1'b0;

        burst[0] = mk(16'h5090, 1, 0, 2'b00, 3'd2, 3'd0, 3'd0,
                      16'h0012, 0, 0, 1);
        burst[1] = mk(16'h1850, 1, 1, 2'b01, 3'd4, 3'd1, 3'd2,
                      16'h0000, 0, 1, 0);
        burst[2] = mk(16'h8000, 0, 0, 2'b00, 3'd0, 3'd0, 3'd0,
                      16'h0000, 0, 0, 0);
        burst[3] = mk(16'h3FA8, 1, 1, 2'b11, 3'd7, 3'd6, 3'd5,
                      16'h0000, 0, 1, 0);
        burst[4] = mk(16'h7D28, 1, 0, 2'b00, 3'd7, 3'd0, 3'd0,
                      16'h00A5, 0, 0, 1);
        burst[5] = mk(16'h21F8, 1, 1, 2'b10, 3'd0, 3'd7, 3'd7,
                      16'h0000, 0, 1, 0);
        burst[6] = mk(16'hFFFF, 0, 0, 2'b00, 3'd0, 3'd0, 3'd0,
                      16'h0000, 1, 0, 0);
        burst[7] = mk(16'h4000, 1, 0, 2'b00, 3'd0, 3'd0, 3'd0,
                      16'h0000, 0, 0, 1);
        done_cyc.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) send(burst[i]);
        wait_idle();
        chk("burst_saw_full", saw_full, 1);
        chk("burst_done_cnt", done_cyc.size(), 8);
        for (int i = 1; i < done_cyc.size(); i++)
            chk("burst_done_gap", done_cyc[i] - done_cyc[i-1], 2);

        bus.cout = 1'b1;
        send(mk(16'hC000, 0, 0, 2'b00, 3'd0, 3'd0, 3'd0,
                16'h0000, 1, 0, 0));
        wait_idle();
        chk("carry_after_rsvd", carry, 0);

        send(mk(16'h0650, 1, 1, 2'b00, 3'd3, 3'd1, 3'd2,
                16'h0000, 0, 1, 0));
        send(mk(16'h4FF8, 1, 0, 2'b00, 3'd1, 3'd0, 3'd0,
                16'h00FF, 0, 0, 1));
        send(mk(16'h8000, 0, 0, 2'b00, 3'd0, 3'd0, 3'd0,
                16'h0000, 0, 0, 0));
        n = 0;
        while (!bus.wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_exec", bus.wr, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_wr", bus.wr, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_in_ready", bus.in_ready, 0);
        mcarry = 1'b0;
        bus.cout = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_carry", carry, 0);
        repeat (6) @(negedge clk);
        chk("post_rst_idle", busy, 0);
        chk("sb_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
